hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline control: drives stall/clr into the F/D and D->E pipeline registers.
//  Detects load-use and Tuse/Tnew data hazards between D and the E/M stages.
//  Tracks multi-cycle mult/div busy time.
//  Sequences an exception/eret flush, which takes priority over any stall.
//  Sits beside the D stage. It is the producer side of the stall/clr inputs of every pipe register.
// PARAMETERS
//  MD_MUL_LAT  5   cycles a mult/multu occupies HI/LO after leaving E
//  MD_DIV_LAT  10  cycles a div/divu occupies HI/LO after leaving E
//  CNT_W       4   busy-counter width; must hold MD_DIV_LAT
// PORTS
//  clk          in   1  rising-edge clock
//  reset        in   1  asynchronous, active-high reset
//  a1_d         in   5  D-stage rs address
//  a2_d         in   5  D-stage rt address
//  tuse_rs_d    in   2  cycles until rs is needed (0..2); 3 = rs unused
//  tuse_rt_d    in   2  cycles until rt is needed (0..2); 3 = rt unused
//  md_use_d     in   1  D instr reads or writes HI/LO (mfhi/mflo/mthi/mtlo/mult/div)
//  res_e        in   3  E result class: 0 NW, 1 ALU, 2 DM, 3 PC, 4 MD
//  a3_e         in   5  E destination register
//  res_m        in   3  M result class, same encoding as res_e
//  a3_m         in   5  M destination register
//  md_start_e   in   1  E instr is mult/div and starts this cycle
//  md_div_e     in   1  with md_start_e: 1 = div latency, 0 = mul latency
//  exc_m        in   1  exception/interrupt taken at M
//  eret_m       in   1  eret at M
//  stall        out  1  hold PC and F/D; combinational
//  clr_e        out  1  insert bubble into D->E register (== stall)
//  flush        out  1  clear all pipe registers; combinational
//  md_busy      out  1  HI/LO unit busy (counter != 0 or md_start_e)
// BEHAVIOUR
//  Reset (async): FSM=RUN, md_cnt=0. Outputs stall=clr_e=flush=0. md_busy=md_start_e.
//  Tnew, E stage: NW 0, ALU 1, DM 2, PC 0, MD 1.
//  Tnew, M stage: DM 1, all other classes 0. Encodings 5..7 are treated as NW.
//  Data hazard on rs: a1_d != 0, and tuse_rs_d != 3, and either
//   - a1_d == a3_e and Tnew_e > tuse_rs_d, or
//   - a1_d == a3_m and Tnew_m > tuse_rs_d.
//  Same rule for rt with a2_d and tuse_rt_d. Writes to $0 never stall.
//  MD counter:
//   - md_start_e && !flush at the posedge: md_cnt <= MD_DIV_LAT if md_div_e, else MD_MUL_LAT.
//   - Otherwise, if md_cnt != 0: md_cnt <= md_cnt - 1. It saturates at 0 and never wraps.
//   - A start while md_cnt != 0 reloads the counter. It does not accumulate.
//  MD stall: md_use_d && md_busy.
//  stall = (data hazard || MD stall) && !flush. clr_e = stall.
//  FSM states:
//   - RUN:   exc_m|eret_m -> FLUSH. flush = exc_m|eret_m.
//   - FLUSH: flush = 1 for this single cycle. Next state is FLUSH if exc_m|eret_m, else RUN.
//  Flush length: a flush lasts 2 cycles, the request cycle plus the FLUSH state.
//  A new request during FLUSH extends the flush by 1 cycle.
//  Exception mid-MD: md_cnt keeps counting, because the started instr is older and committed.
//   A md_start_e in a flush cycle is dropped.
//  Reset mid-flush or mid-MD: immediate return to RUN with md_cnt=0.
//  Latency: stall and flush react in the same cycle as their inputs. No registered outputs.
// CONFIGURATION
//  HAZARD_CTRL_STALL_CNT_EN
//   - Defined: adds output stall_cnt [31:0]. It increments on every clk edge where stall=1.
//     Reset to 0. Wraps 0xFFFFFFFF->0. Does not count flush cycles.
//   - Undefined: port and counter are absent. All other behaviour is identical.
// TESTING
//  1 lw $t0 in E (res_e=2, a3_e=8), D reads a1_d=8 tuse_rs_d=1 -> stall=clr_e=1 for 1 cycle;
//    next cycle res_m=2, a3_m=8 -> stall=0.
//  2 a3_e=0, res_e=1, a1_d=0, tuse_rs_d=0 -> stall=0. With tuse_rs_d=3 and any match -> stall=0.
//  3 md_start_e=1, md_div_e=1, then md_use_d=1 held -> md_busy and stall high for exactly
//    11 cycles (start + 10). With md_div_e=0: 6 cycles.
//  4 Data hazard active and exc_m=1 in the same cycle -> flush=1, stall=0. Next cycle flush=1
//    (FLUSH). Following cycle flush=0.
//  5 eret_m pulses in RUN, then exc_m in the FLUSH cycle -> flush high 3 consecutive cycles.
//  6 reset asserted while md_cnt=7 in FLUSH -> md_cnt=0, flush=0, stall=0 immediately.
//    With HAZARD_CTRL_STALL_CNT_EN: stall_cnt=0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard-control signal bundle between the D/E/M pipeline stages and hazard_ctrl.
// slave = hazard unit side, master = pipeline (or bench) side.
interface hazard_ctrl_if;
    logic [4:0] a1_d;
    logic [4:0] a2_d;
    logic [1:0] tuse_rs_d;
    logic [1:0] tuse_rt_d;
    logic       md_use_d;
    logic [2:0] res_e;
    logic [4:0] a3_e;
    logic [2:0] res_m;
    logic [4:0] a3_m;
    logic       md_start_e;
    logic       md_div_e;
    logic       exc_m;
    logic       eret_m;
    logic       stall;
    logic       clr_e;
    logic       flush;
    logic       md_busy;

    modport slave (
        input  a1_d, a2_d, tuse_rs_d, tuse_rt_d, md_use_d,
        input  res_e, a3_e, res_m, a3_m,
        input  md_start_e, md_div_e, exc_m, eret_m,
        output stall, clr_e, flush, md_busy
    );

    modport master (
        output a1_d, a2_d, tuse_rs_d, tuse_rt_d, md_use_d,
        output res_e, a3_e, res_m, a3_m,
        output md_start_e, md_div_e, exc_m, eret_m,
        input  stall, clr_e, flush, md_busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: Tuse/Tnew data stalls, HI/LO busy tracking, exception/eret flush.
// Optional HAZARD_CTRL_STALL_CNT_EN adds a free-running 32-bit stall-cycle counter.
module hazard_ctrl #(
    parameter int MD_MUL_LAT = 5,
    parameter int MD_DIV_LAT = 10,
    parameter int CNT_W      = 4
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
`ifdef HAZARD_CTRL_STALL_CNT_EN
    ,
    output logic [31:0]  stall_cnt
`endif
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_md_cnt;
    logic               w_req;
    logic               w_flush_raw;
    logic               w_flush;
    logic               w_hazard;
    logic               w_md_busy;
    logic               w_stall;

    function automatic logic [1:0] tnew_e(input logic [2:0] res);
        case (res)
            3'd1:    tnew_e = 2'd1;
            3'd2:    tnew_e = 2'd2;
            3'd4:    tnew_e = 2'd1;
            default: tnew_e = 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] tnew_m(input logic [2:0] res);
        tnew_m = (res == 3'd2) ? 2'd1 : 2'd0;
    endfunction

    // A source stalls only when a younger-than-needed result is still in flight; $0 never does.
    function automatic logic src_hazard(
        input logic [4:0] addr,
        input logic [1:0] tuse,
        input logic [4:0] a3_e,
        input logic [2:0] res_e,
        input logic [4:0] a3_m,
        input logic [2:0] res_m
    );
        src_hazard = (addr != 5'd0) && (tuse != 2'd3) &&
                     (((addr == a3_e) && (tnew_e(res_e) > tuse)) ||
                      ((addr == a3_m) && (tnew_m(res_m) > tuse)));
    endfunction

    assign w_req = hz.exc_m | hz.eret_m;

    always_comb begin
        w_state_nxt = r_state;
        w_flush_raw = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_flush_raw = w_req;
                if (w_req) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                w_flush_raw = 1'b1;
                w_state_nxt = w_req ? ST_FLUSH : ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_RUN;
        else       r_state <= w_state_nxt;
    end

    assign w_hazard = src_hazard(hz.a1_d, hz.tuse_rs_d, hz.a3_e, hz.res_e, hz.a3_m, hz.res_m) ||
                      src_hazard(hz.a2_d, hz.tuse_rt_d, hz.a3_e, hz.res_e, hz.a3_m, hz.res_m);

    assign w_md_busy = (r_md_cnt != '0) || hz.md_start_e;
    assign w_flush   = w_flush_raw && !reset;
    assign w_stall   = (w_hazard || (hz.md_use_d && w_md_busy)) && !w_flush && !reset;

    // Flush drops the start of the killed instruction but lets an older, committed op keep counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_md_cnt <= '0;
        end else if (hz.md_start_e && !w_flush) begin
            r_md_cnt <= hz.md_div_e ? CNT_W'(MD_DIV_LAT) : CNT_W'(MD_MUL_LAT);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - 1'b1;
        end
    end

    assign hz.stall   = w_stall;
    assign hz.clr_e   = w_stall;
    assign hz.flush   = w_flush;
    assign hz.md_busy = w_md_busy;

`ifdef HAZARD_CTRL_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        r_stall_cnt <= '0;
        else if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-count based reference model.
module tb_hazard_ctrl;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic clk;
    logic reset;
    hazard_ctrl_if hz ();
`ifdef HAZARD_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    hazard_ctrl #(
        .MD_MUL_LAT (MUL_LAT),
        .MD_DIV_LAT (DIV_LAT),
        .CNT_W      (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
`ifdef HAZARD_CTRL_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: cycle index, last cycle HI/LO is still busy, previous flush request.
    int          cyc      = 0;
    int          busy_end = -1;
    bit          prev_req = 1'b0;
    logic [31:0] m_scnt   = '0;
    int          tnew_e_tab [8] = '{0, 1, 2, 0, 1, 0, 0, 0};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic bit needs_stall(input int a, input int tuse);
        int tn_m;
        if (a == 0 || tuse == 3) return 1'b0;
        tn_m = (hz.res_m == 3'd2) ? 1 : 0;
        return ((a == int'(hz.a3_e)) && (tnew_e_tab[hz.res_e] > tuse)) ||
               ((a == int'(hz.a3_m)) && (tn_m > tuse));
    endfunction

    task automatic idle();
        hz.a1_d = '0; hz.a2_d = '0; hz.tuse_rs_d = 2'd3; hz.tuse_rt_d = 2'd3;
        hz.md_use_d = 1'b0; hz.res_e = '0; hz.a3_e = '0; hz.res_m = '0; hz.a3_m = '0;
        hz.md_start_e = 1'b0; hz.md_div_e = 1'b0; hz.exc_m = 1'b0; hz.eret_m = 1'b0;
    endtask

    // Called once per cycle right after inputs change at the negedge.
    task automatic step(input string tag);
        bit req, haz, e_flush, e_busy, e_stall;
        #1;
        if (reset) begin
            prev_req = 1'b0;
            busy_end = -1;
            m_scnt   = '0;
        end
        req     = hz.exc_m || hz.eret_m;
        haz     = needs_stall(int'(hz.a1_d), int'(hz.tuse_rs_d)) ||
                  needs_stall(int'(hz.a2_d), int'(hz.tuse_rt_d));
        e_flush = !reset && (req || prev_req);
        e_busy  = hz.md_start_e || (cyc <= busy_end);
        e_stall = !reset && !e_flush && (haz || (hz.md_use_d && e_busy));
        chk({tag, "_stall"},   32'(hz.stall),   32'(e_stall));
        chk({tag, "_clr_e"},   32'(hz.clr_e),   32'(e_stall));
        chk({tag, "_flush"},   32'(hz.flush),   32'(e_flush));
        chk({tag, "_md_busy"}, 32'(hz.md_busy), 32'(e_busy));
`ifdef HAZARD_CTRL_STALL_CNT_EN
        chk({tag, "_stall_cnt"}, stall_cnt, m_scnt);
`endif
        if (!reset) begin
            if (hz.md_start_e && !e_flush) busy_end = cyc + (hz.md_div_e ? DIV_LAT : MUL_LAT);
            prev_req = req;
            if (e_stall) m_scnt = m_scnt + 32'd1;
        end
        cyc++;
    endtask

    initial begin
        int n;
        idle();
        reset = 1'b1;
        @(negedge clk); step("rst");
        chk("rst_flush0", 32'(hz.flush), 32'd0);
        @(negedge clk); reset = 1'b0; step("rst_rel");

        // 1: load-use against E, then the same load in M no longer stalls
        @(negedge clk); idle(); hz.res_e = 3'd2; hz.a3_e = 5'd8; hz.a1_d = 5'd8; hz.tuse_rs_d = 2'd1;
        step("t1a"); chk("t1_stall_e", 32'(hz.stall), 32'd1);
        @(negedge clk); idle(); hz.res_m = 3'd2; hz.a3_m = 5'd8; hz.a1_d = 5'd8; hz.tuse_rs_d = 2'd1;
        step("t1b"); chk("t1_stall_m", 32'(hz.stall), 32'd0);

        // 2: $0 and unused sources never stall
        @(negedge clk); idle(); hz.res_e = 3'd1; hz.tuse_rs_d = 2'd0;
        step("t2a"); chk("t2_zero", 32'(hz.stall), 32'd0);
        @(negedge clk); idle(); hz.res_e = 3'd2; hz.a3_e = 5'd9; hz.a1_d = 5'd9; hz.a2_d = 5'd9;
        step("t2b"); chk("t2_unused", 32'(hz.stall), 32'd0);

        // 3: div then mul occupancy seen by an HI/LO user
        for (int k = 0; k < 2; k++) begin
            n = 0;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk); idle(); hz.md_use_d = 1'b1;
                if (c == 0) begin hz.md_start_e = 1'b1; hz.md_div_e = (k == 0); end
                step("t3");
                if (hz.stall) n++;
            end
            chk(k == 0 ? "t3_div_len" : "t3_mul_len", n, k == 0 ? 32'd11 : 32'd6);
        end

        // 4: flush beats a simultaneous data hazard
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); idle(); hz.res_e = 3'd2; hz.a3_e = 5'd8; hz.a1_d = 5'd8; hz.tuse_rs_d = 2'd0;
            hz.exc_m = (c == 0);
            step("t4");
            chk("t4_flush", 32'(hz.flush), c < 2 ? 32'd1 : 32'd0);
            chk("t4_stall", 32'(hz.stall), c < 2 ? 32'd0 : 32'd1);
        end

        // 5: eret followed by exc during FLUSH stretches flush to three cycles
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); idle(); hz.eret_m = (c == 0); hz.exc_m = (c == 1);
            step("t5"); chk("t5_flush", 32'(hz.flush), c < 3 ? 32'd1 : 32'd0);
        end

        // 6: reset while in FLUSH with the divider counter part-way down
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); idle(); hz.md_start_e = (c == 0); hz.md_div_e = 1'b1; hz.exc_m = (c == 3);
            step("t6pre");
        end
        @(negedge clk); idle(); hz.md_use_d = 1'b1; hz.exc_m = 1'b1; reset = 1'b1;
        step("t6");
        chk("t6_flush", 32'(hz.flush), 32'd0);
        chk("t6_busy", 32'(hz.md_busy), 32'd0);
`ifdef HAZARD_CTRL_STALL_CNT_EN
        chk("t6_scnt", stall_cnt, 32'd0);
`endif
        @(negedge clk); idle(); reset = 1'b0; step("t6rel");

        // Randomized traffic with narrow address ranges so matches are frequent
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            reset         = ($urandom_range(199) == 0);
            hz.a1_d       = 5'($urandom_range(3));
            hz.a2_d       = 5'($urandom_range(3));
            hz.tuse_rs_d  = 2'($urandom_range(3));
            hz.tuse_rt_d  = 2'($urandom_range(3));
            hz.md_use_d   = ($urandom_range(2) == 0);
            hz.res_e      = 3'($urandom_range(7));
            hz.a3_e       = 5'($urandom_range(3));
            hz.res_m      = 3'($urandom_range(7));
            hz.a3_m       = 5'($urandom_range(3));
            hz.md_start_e = ($urandom_range(9) == 0);
            hz.md_div_e   = 1'($urandom_range(1));
            hz.exc_m      = ($urandom_range(11) == 0);
            hz.eret_m     = ($urandom_range(13) == 0);
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
